// File: rtl/sparse_qc_mult.sv
// sparse_qc_mult: quasi-cyclic sparse GF(2) matrix multiplier on valid/ready streams.
// A block of IN_LEN input words is captured into one of two ping-pong banks; while
// the next block fills the other bank, OUT_LEN product words are drained, each the
// XOR of the enabled taps of its row applied to the stored words (rotated left).
module sparse_qc_mult #(
   parameter int WIDTH   = 96,
   parameter int IN_LEN  = 1,
   parameter int OUT_LEN = 11,
   parameter int SHIFT_W = $clog2(WIDTH),
   parameter int ENTRY_W = SHIFT_W + 1,
   parameter logic [OUT_LEN*IN_LEN*ENTRY_W-1:0] TAP_TABLE = 88'h0000000000800000000087
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_input_data,
   input  logic             i_input_valid,
   output logic             o_input_ready,
   output logic [WIDTH-1:0] o_output_data,
   output logic             o_output_valid,
   output logic             o_output_last,
   input  logic             i_output_ready
);

   localparam int IN_CNT_W  = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
   localparam int OUT_CNT_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
   localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(IN_LEN - 1);
   localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_LEN - 1);

   // A rotate amount of WIDTH or more in an enabled tap cannot be realised.
   for (genvar g = 0; g < OUT_LEN * IN_LEN; g++) begin : g_tap_check
      if (TAP_TABLE[g*ENTRY_W + ENTRY_W - 1] &&
          (int'(TAP_TABLE[g*ENTRY_W +: SHIFT_W]) >= WIDTH)) begin : g_bad_shift
         $error("sparse_qc_mult: tap %0d has shift >= WIDTH", g);
      end
   end

   // Left rotate through a doubled word: the upper half of {d,d}<<s is rotl(d,s).
   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                             input logic [SHIFT_W-1:0] s);
      logic [2*WIDTH-1:0] dd;
      dd = {d, d} << s;
      return dd[2*WIDTH-1:WIDTH];
   endfunction

   logic [WIDTH-1:0]     bank_mem_r [2][IN_LEN];
   logic [1:0]           bank_full_r;
   logic [1:0]           bank_full_next_s;
   logic                 wr_bank_r;
   logic                 rd_bank_r;
   logic [IN_CNT_W-1:0]  in_count_r;
   logic [OUT_CNT_W-1:0] out_count_r;
   logic                 in_accept_s;
   logic                 out_accept_s;
   logic                 fill_done_s;
   logic                 drain_done_s;
   logic [WIDTH-1:0]     acc_s;
   logic [ENTRY_W-1:0]   entry_s;

   assign o_input_ready  = ~bank_full_r[wr_bank_r];
   assign o_output_valid = bank_full_r[rd_bank_r];
   assign o_output_last  = o_output_valid & (out_count_r == OUT_LAST);
   assign o_output_data  = o_output_valid ? acc_s : {WIDTH{1'b0}};

   assign in_accept_s  = i_input_valid & o_input_ready;
   assign out_accept_s = o_output_valid & i_output_ready;
   assign fill_done_s  = in_accept_s & (in_count_r == IN_LAST);
   assign drain_done_s = out_accept_s & (out_count_r == OUT_LAST);

   // Bank occupancy: fill and drain completions always hit different banks.
   always_comb begin
      bank_full_next_s = bank_full_r;
      if (fill_done_s) begin
         bank_full_next_s[wr_bank_r] = 1'b1;
      end else begin
         bank_full_next_s = bank_full_next_s;
      end
      if (drain_done_s) begin
         bank_full_next_s[rd_bank_r] = 1'b0;
      end else begin
         bank_full_next_s = bank_full_next_s;
      end
   end

   // Block sequencing: word counters, bank pointers and occupancy flags.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         bank_full_r <= 2'b00;
         wr_bank_r   <= 1'b0;
         rd_bank_r   <= 1'b0;
         in_count_r  <= '0;
         out_count_r <= '0;
      end else begin
         bank_full_r <= bank_full_next_s;
         if (in_accept_s) begin
            if (in_count_r == IN_LAST) begin
               in_count_r <= '0;
               wr_bank_r  <= ~wr_bank_r;
            end else begin
               in_count_r <= in_count_r + 1'b1;
            end
         end
         if (out_accept_s) begin
            if (out_count_r == OUT_LAST) begin
               out_count_r <= '0;
               rd_bank_r   <= ~rd_bank_r;
            end else begin
               out_count_r <= out_count_r + 1'b1;
            end
         end
      end
   end

   // Word storage; contents are don't-care until the bank is marked full.
   always_ff @(posedge i_clock) begin
      if (in_accept_s && !i_reset) begin
         bank_mem_r[wr_bank_r][in_count_r] <= i_input_data;
      end
   end

   // Product for the current output row, built only from registered state.
   always_comb begin
      acc_s   = {WIDTH{1'b0}};
      entry_s = {ENTRY_W{1'b0}};
      for (int i = 0; i < IN_LEN; i++) begin
         entry_s = TAP_TABLE[(int'(out_count_r) * IN_LEN + i) * ENTRY_W +: ENTRY_W];
         if (entry_s[ENTRY_W-1]) begin
            acc_s = acc_s ^ rotl(bank_mem_r[rd_bank_r][IN_CNT_W'(i)], entry_s[SHIFT_W-1:0]);
         end else begin
            acc_s = acc_s;
         end
      end
   end

endmodule

// File: tb/tb_sparse_qc_mult.sv
// Directed and streaming checks for sparse_qc_mult (default and a small configuration).
module tb_sparse_qc_mult;

   localparam int W      = 96;
   localparam int OL     = 11;
   localparam int NBLK   = 1000;
   localparam int BUDGET = 60000;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [W-1:0] d_in_data;
   logic         d_in_valid;
   logic         d_in_ready;
   logic [W-1:0] d_out_data;
   logic         d_out_valid;
   logic         d_out_last;
   logic         d_out_ready;

   logic [7:0]   s_in_data;
   logic         s_in_valid;
   logic         s_in_ready;
   logic [7:0]   s_out_data;
   logic         s_out_valid;
   logic         s_out_last;
   logic         s_out_ready;

   sparse_qc_mult dut (
      .i_clock(clock), .i_reset(reset),
      .i_input_data(d_in_data), .i_input_valid(d_in_valid), .o_input_ready(d_in_ready),
      .o_output_data(d_out_data), .o_output_valid(d_out_valid), .o_output_last(d_out_last),
      .i_output_ready(d_out_ready)
   );

   sparse_qc_mult #(
      .WIDTH(8), .IN_LEN(2), .OUT_LEN(3), .TAP_TABLE(24'hC00089)
   ) dut_s (
      .i_clock(clock), .i_reset(reset),
      .i_input_data(s_in_data), .i_input_valid(s_in_valid), .o_input_ready(s_in_ready),
      .o_output_data(s_out_data), .o_output_valid(s_out_valid), .o_output_last(s_out_last),
      .i_output_ready(s_out_ready)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] din;
      logic [W-1:0] e0;
      logic [W-1:0] e5;
   } vec_t;
   vec_t vecs [6];

   logic [W-1:0] sb_q [$];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference for the default taps: row 0 = rotl(d,7), row 5 = d, others zero.
   function automatic logic [W-1:0] exp_word(input logic [W-1:0] d, input int j);
      if (j == 0) return {d[88:0], d[95:89]};
      else if (j == 5) return d;
      else return '0;
   endfunction

   // Drain a whole default block from word 0 against a table entry.
   task automatic drain_vec(input int v, input string tag);
      logic [W-1:0] e;
      d_out_ready = 1'b1;
      for (int j = 0; j < OL; j++) begin
         e = (j == 0) ? vecs[v].e0 : ((j == 5) ? vecs[v].e5 : '0);
         check({tag, "_valid"}, W'(d_out_valid), W'(1));
         check({tag, "_data"}, d_out_data, e);
         check({tag, "_last"}, W'(d_out_last), W'(j == OL - 1));
         tick();
      end
   endtask

   initial begin
      vecs[0] = '{din: 96'h1, e0: 96'h80, e5: 96'h1};
      vecs[1] = '{din: 96'h8000_0000_0000_0000_0000_0000, e0: 96'h40,
                  e5: 96'h8000_0000_0000_0000_0000_0000};
      vecs[2] = '{din: 96'hF000_0000_0000_0000_0000_0001, e0: 96'hF8,
                  e5: 96'hF000_0000_0000_0000_0000_0001};
      vecs[3] = '{din: 96'h0100_0000_0000_0000_0000_0000, e0: 96'h8000_0000_0000_0000_0000_0000,
                  e5: 96'h0100_0000_0000_0000_0000_0000};
      vecs[4] = '{din: 96'h0200_0000_0000_0000_0000_0000, e0: 96'h1,
                  e5: 96'h0200_0000_0000_0000_0000_0000};
      vecs[5] = '{din: 96'hFF, e0: 96'h7F80, e5: 96'hFF};

      reset = 1'b1;
      d_in_data = '0; d_in_valid = 1'b0; d_out_ready = 1'b0;
      s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      tick(); tick(); tick();
      check("rst_in_ready", W'(d_in_ready), W'(1));
      check("rst_out_valid", W'(d_out_valid), W'(0));
      check("rst_out_last", W'(d_out_last), W'(0));
      check("rst_out_data", d_out_data, '0);
      check("rst_s_valid", W'(s_out_valid), W'(0));
      reset = 1'b0;
      tick();

      // Table-driven single blocks.
      for (int v = 0; v < 6; v++) begin
         d_out_ready = 1'b0;
         check("vec_in_ready", W'(d_in_ready), W'(1));
         d_in_data = vecs[v].din; d_in_valid = 1'b1;
         tick();
         d_in_valid = 1'b0;
         check("vec_latency", W'(d_out_valid), W'(1));
         drain_vec(v, "vec");
         check("vec_idle", W'(d_out_valid), W'(0));
         d_out_ready = 1'b0;
      end

      // Small configuration: two input words, three output rows.
      s_in_data = 8'h81; s_in_valid = 1'b1;
      tick();
      check("s_partial_valid", W'(s_out_valid), W'(0));
      s_in_data = 8'h0F;
      tick();
      s_in_valid = 1'b0;
      check("s_valid", W'(s_out_valid), W'(1));
      check("s_in_ready", W'(s_in_ready), W'(1));
      s_out_ready = 1'b1;
      check("s_out0", W'(s_out_data), W'(8'h0C)); check("s_last0", W'(s_out_last), W'(0)); tick();
      check("s_out1", W'(s_out_data), W'(8'h00)); check("s_last1", W'(s_out_last), W'(0)); tick();
      check("s_out2", W'(s_out_data), W'(8'hF0)); check("s_last2", W'(s_out_last), W'(1)); tick();
      check("s_idle", W'(s_out_valid), W'(0));
      s_out_ready = 1'b0;

      // Backpressure: both banks fill, third word waits for a drain.
      d_out_ready = 1'b0;
      d_in_valid = 1'b1; d_in_data = vecs[0].din;
      tick();
      check("bp_ready_after1", W'(d_in_ready), W'(1));
      d_in_data = vecs[1].din;
      tick();
      check("bp_ready_after2", W'(d_in_ready), W'(0));
      d_in_data = vecs[2].din;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("bp_stall_ready", W'(d_in_ready), W'(0));
         check("bp_stall_data", d_out_data, vecs[0].e0);
         check("bp_stall_valid", W'(d_out_valid), W'(1));
      end
      d_out_ready = 1'b1;
      for (int j = 0; j < OL; j++) begin
         check("bp_blk1_data", d_out_data, exp_word(vecs[0].din, j));
         check("bp_ready_hold", W'(d_in_ready), W'(0));
         tick();
      end
      check("bp_ready_restore", W'(d_in_ready), W'(1));
      d_out_ready = 1'b0;
      tick();
      d_in_valid = 1'b0;
      check("bp_ready_after3", W'(d_in_ready), W'(0));
      drain_vec(1, "bp_blk2");
      drain_vec(2, "bp_blk3");
      check("bp_idle", W'(d_out_valid), W'(0));
      d_out_ready = 1'b0;

      // Reset in the middle of a drain.
      d_in_data = vecs[2].din; d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      d_out_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         check("mr_pre_data", d_out_data, exp_word(vecs[2].din, j));
         tick();
      end
      reset = 1'b1;
      tick();
      check("mr_valid", W'(d_out_valid), W'(0));
      check("mr_data", d_out_data, '0);
      check("mr_last", W'(d_out_last), W'(0));
      check("mr_in_ready", W'(d_in_ready), W'(1));
      reset = 1'b0;
      tick(); tick();
      check("mr_quiet", W'(d_out_valid), W'(0));
      d_out_ready = 1'b0;
      d_in_data = vecs[3].din; d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      drain_vec(3, "mr_next");
      d_out_ready = 1'b0;

      // Streaming with random stalls on both sides.
      fork
         begin : producer
            int sent = 0;
            int pcyc = 0;
            logic acc;
            d_in_valid = 1'b0;
            while (sent < NBLK && pcyc < BUDGET) begin
               if (!d_in_valid && $urandom_range(0, 3) != 0) begin
                  d_in_data = {$urandom(), $urandom(), $urandom()};
                  d_in_valid = 1'b1;
               end
               acc = d_in_valid & d_in_ready;
               if (acc) sb_q.push_back(d_in_data);
               tick();
               pcyc++;
               if (acc) begin
                  sent++;
                  d_in_valid = 1'b0;
               end
            end
            d_in_valid = 1'b0;
         end
         begin : consumer
            int got = 0;
            int ccyc = 0;
            int oidx = 0;
            while (got < NBLK * OL && ccyc < BUDGET) begin
               d_out_ready = ($urandom_range(0, 3) != 0);
               if (d_out_valid && d_out_ready) begin
                  if (sb_q.size() == 0) begin
                     check("st_extra_word", W'(1), W'(0));
                  end else begin
                     check("st_data", d_out_data, exp_word(sb_q[0], oidx));
                     check("st_last", W'(d_out_last), W'(oidx == OL - 1));
                     if (oidx == OL - 1) begin
                        void'(sb_q.pop_front());
                        oidx = 0;
                     end else begin
                        oidx++;
                     end
                  end
                  got++;
               end
               tick();
               ccyc++;
            end
            d_out_ready = 1'b0;
            check("st_word_count", W'(got), W'(NBLK * OL));
         end
      join
      check("st_queue_empty", W'(sb_q.size()), W'(0));
      tick();
      check("st_final_idle", W'(d_out_valid), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sparse_qc_mult.md
Name: sparse_qc_mult

Overview:
- Generalised quasi-cyclic sparse GF(2) matrix multiplier for streaming bit-vector blocks.
- Each block of IN_LEN input words, WIDTH bits each, produces OUT_LEN output words.
- Output word j is the XOR over all input words i of rotl(input[i], shift[j][i]), or 0 where tap (j,i) is disabled.
- Ping-pong banked so one block fills while the previous block drains. Sits between the encoder front-end and the next matrix stage on valid/ready streams.

Parameters:
- WIDTH, 96, bits per word (≥2).
- IN_LEN, 1, input words per block (≥1).
- OUT_LEN, 11, output words per block (≥1).
- SHIFT_W, $clog2(WIDTH), width of the rotate-amount field.
- ENTRY_W, SHIFT_W+1, tap entry width; msb = enable, lsbs = left-rotate amount.
- TAP_TABLE, 88'h0000000000800000000087, packed OUT_LEN*IN_LEN entries.
  - Entry (j,i) sits at bit offset (j*IN_LEN+i)*ENTRY_W.
  - The default gives out0 = rotl(in0,7), out5 = in0, all others 0.

Ports:
- i_clock, in, 1: clock.
- i_reset, in, 1: reset i_reset, synchronous, active-high; clock i_clock.
- i_input_data, in, WIDTH: input word.
- i_input_valid, in, 1: input word valid.
- o_input_ready, out, 1: block can accept a word.
- o_output_data, out, WIDTH: product word.
- o_output_valid, out, 1: product word valid.
- o_output_last, out, 1: high on word OUT_LEN-1 of a block.
- i_output_ready, in, 1: downstream accepts.

Behaviour:
- Storage: two banks (0/1), each IN_LEN x WIDTH registers. Also bank_full[1:0], wr_bank, rd_bank, in_count (0..IN_LEN-1), out_count (0..OUT_LEN-1).
- Reset: bank_full=0, wr_bank=0, rd_bank=0, in_count=0, out_count=0. Outputs after reset: o_input_ready=1, o_output_valid=0, o_output_last=0, o_output_data=0. Storage contents need not be cleared.
- o_input_ready = !bank_full[wr_bank]. Input accept = i_input_valid & o_input_ready.
- On accept:
  - Store the word at bank[wr_bank][in_count].
  - If in_count==IN_LEN-1: in_count→0, bank_full[wr_bank]→1, wr_bank toggles.
  - Otherwise in_count+1.
- o_output_valid = bank_full[rd_bank]. Output accept = o_output_valid & i_output_ready.
- On output accept:
  - If out_count==OUT_LEN-1: out_count→0, bank_full[rd_bank]→0, rd_bank toggles.
  - Otherwise out_count+1.
- o_output_data:
  - When valid, XOR over i of the enabled taps for row out_count, each rotated left by its shift. Rotate-left by s means {d[WIDTH-1-s:0], d[WIDTH-1:WIDTH-s]}; s=0 is identity.
  - When not valid, o_output_data=0.
- o_output_last = o_output_valid & (out_count==OUT_LEN-1).
- Output data/valid/last depend on registers only; there is no combinational path from i_input_* or i_output_ready.
- Latency: the first output word is valid on the cycle after the last input word of the block is accepted.
- Data stability: valid and data hold stable while valid=1 and ready=0.
- Simultaneous fill-complete and drain-complete: these always target different banks, so both take effect in the same cycle.
- Ready restore: when both banks are full and drain completes, o_input_ready rises on the next cycle.
- Throughput: with i_output_ready=1, the block sustains 1 word/cycle on the slower side, with no bubble between blocks.
- All-disabled row: output is 0 but still valid and counted.
- Shift ≥ WIDTH in an enabled entry is illegal; an elaboration-time assertion flags it.
- Reset mid-block discards partially filled and partially drained blocks. No output is emitted afterwards until a full new block arrives.
- Counters wrap only at block ends; in_count and out_count are independent.

Test Plan:
- Default params, input 96'h1: outputs in order are 0:96'h80, 1-4:0, 5:96'h1, 6-10:0. o_output_last is high only on word 10.
- Default params, input with bit 95 set only: word0 = 96'h40 (bit 6), word5 = bit 95. Confirms rotate wrap.
- IN_LEN=2, OUT_LEN=3, WIDTH=8, taps (0,0)=s1, (0,1)=s0, (2,1)=s4; inputs 8'h81, 8'h0F:
  - out0 = 8'h03^8'h0F = 8'h0C.
  - out1 = 8'h00.
  - out2 = 8'hF0.
- Backpressure, default params: hold i_output_ready=0 and send 3 words.
  - Words 1 and 2 are accepted; o_input_ready goes 0 after the 2nd.
  - After 11 output accepts, ready returns the next cycle and word 3 is accepted.
  - Output blocks match words 1 then 2.
- Continuous streaming: valid=1 and ready=1 with random stalls on both sides over 1000 blocks. Scoreboard shows zero mismatches and no dropped or duplicated words.
- Reset asserted after output word 4 of a block: all outputs read 0 the next cycle and o_input_ready=1. The next block's outputs are correct and start at word 0.
